eth_phy_10g_rx_ber_mon: RTL and testbench
=========================================

# eth_phy_10g_rx_ber_mon

Receive-side 64b/66b bit-error-rate monitor, sitting directly downstream of the RX sync-header aligner in the 10G PHY. It consumes the aligned sync header and the aligner's `aligned` (block lock) flag, and counts invalid sync headers in fixed 125 µs windows. It raises `rx_high_ber` when a window collects `BER_THRESH` bad headers, and keeps a saturating cumulative error counter for management reads.

## Interface
- `HDR_WIDTH`, 2, sync header width; only 2 is supported.
- `COUNT_125US`, 19531, clock cycles per BER window (125 µs at 156.25 MHz); minimum 2.
- `BER_THRESH`, 16, bad headers per window that declare high BER; range 1..63.
- `clk_tb` input 1: clock; all logic on the rising edge.
- `rx_rst_tb` input 1: reset, asynchronous, active-high.
- `serdes_rx_hdr` input `HDR_WIDTH`: aligned sync header from the aligner, one per cycle.
- `aligned` input 1: block lock from the aligner.
- `ber_count_clr` input 1: one-cycle pulse that clears `ber_count`.
- `rx_high_ber` output 1: high-BER status, registered.
- `ber_count` output 6: cumulative bad-header count, saturates at 63.
- `win_err_count` output 6: bad headers counted in the current window, registered.

## Operation
- **Header validity.** `01` and `10` are valid. `00` and `11` are bad.
- **Internal registers.**
  - `state` ∈ {INIT, TEST, HI_BER}.
  - `timer`, clog2(`COUNT_125US`) bits.
  - `win_err_count`.
- **INIT**
  - Holds `timer`=0, `win_err_count`=0, `rx_high_ber`=0.
  - At an edge sampling `aligned`=1: go to TEST with `timer`=0. The header in that cycle is not evaluated.
- **TEST**, every edge:
  - `timer` increments. At `COUNT_125US`-1 it wraps to 0; that edge is the "expiry".
  - A bad header increments `win_err_count`.
  - If the increment reaches `BER_THRESH`:
    - go to HI_BER;
    - set `rx_high_ber`=1;
    - restart `timer` at 0;
    - clear `win_err_count`.
  - Otherwise, on expiry:
    - set `rx_high_ber`=0;
    - clear `win_err_count`;
    - stay in TEST.
  - On expiry the bad header sampled in that same cycle is not added to the new window.
- **HI_BER**
  - Headers are not counted into `win_err_count`, which stays 0.
  - `timer` runs as in TEST.
  - On expiry: go to TEST. `rx_high_ber` stays 1 until a full TEST window ends below threshold.
- **Threshold vs expiry.** Threshold reached on the expiry edge: the threshold wins (HI_BER, `rx_high_ber`=1, timer restarts).
- **Loss of lock.** `aligned`=0 sampled in any state: next edge goes to INIT and clears `timer`, `win_err_count` and `rx_high_ber`. This takes priority over every other transition.
- **`ber_count`**
  - Increments on every bad header sampled while in TEST or HI_BER. It does not count in INIT.
  - Saturates at 63.
  - `ber_count_clr` alone forces 0.
  - `ber_count_clr` and a counted bad header in the same cycle give 1.
  - Unaffected by loss of lock; cleared only by reset or `ber_count_clr`.
- **Reset.** Asynchronous. State INIT; `timer`, `win_err_count`, `ber_count` = 0; `rx_high_ber`=0.

## Timing
- All outputs are registered. The combinational path from inputs to outputs is 0.
- `rx_high_ber` rises on the edge that samples the `BER_THRESH`-th bad header of a window, so it is visible one cycle after that header is presented.
- `rx_high_ber` falls on the expiry edge of the first TEST window that ends below threshold. Minimum high time is 2×`COUNT_125US` cycles: the HI_BER remainder plus one full TEST window.
- A TEST window spans exactly `COUNT_125US` consecutive sampled headers, edge after entry through the expiry edge inclusive. The expiry-edge header is counted only for the threshold check and `ber_count`.
- `ber_count` and `win_err_count` update on the same edge as the sampled header.
- `aligned` falling to INIT: one edge. INIT back to TEST: one edge after `aligned` is seen high.
- Reset mid-operation: outputs clear immediately, asynchronously. The first edge after reset release with `aligned`=1 enters TEST.

## Test plan
Settings for all scenarios: `COUNT_125US`=100, `BER_THRESH`=16.

1. **Reset/idle.** Hold `rx_rst_tb` for 50 cycles, release with `aligned`=0 and `serdes_rx_hdr`=`11`. Expect all outputs at 0 throughout and `ber_count` stays 0.
2. **Clean link.** `aligned`=1, headers alternating `01`/`10` for 1000 cycles. Expect `rx_high_ber`=0, `ber_count`=0, and `win_err_count`=0 throughout.
3. **Threshold edge.**
   - 15 bad headers in one window: expect `rx_high_ber` stays 0 and `win_err_count` clears at expiry.
   - 16 bad headers in the next window: expect `rx_high_ber`=1 on the edge of the 16th, and `ber_count`=31.
4. **Recovery.** After scenario 3, feed clean headers. Expect `rx_high_ber` remains 1 through the HI_BER remainder plus one full 100-cycle TEST window, then drops on that expiry edge.
5. **Boundary and lock loss.**
   - 15 errors, then the 16th bad header on the expiry cycle: expect `rx_high_ber`=1.
   - Then deassert `aligned` for one cycle: expect `rx_high_ber`=0 and `win_err_count`=0 on the next edge, with `ber_count` held.
6. **Counter saturation and clear.**
   - 100 consecutive `00` headers: expect `ber_count`=63, held there.
   - `ber_count_clr` with a bad header: expect 1.
   - `ber_count_clr` with a valid header: expect 0.

Source files
------------

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// 64b/66b receive BER monitor.
// Counts invalid sync headers in fixed windows of COUNT_125US cycles while the
// aligner reports block lock. A window reaching BER_THRESH bad headers raises
// rx_high_ber. The flag is held through the rest of that HI_BER window and one
// further clean TEST window. A saturating cumulative counter, ber_count, is
// kept for management reads and is cleared only by reset or ber_count_clr.
module eth_phy_10g_rx_ber_mon #(
    parameter int HDR_WIDTH   = 2,
    parameter int COUNT_125US = 19531,
    parameter int BER_THRESH  = 16
) (
    input  logic                 clk_tb,
    input  logic                 rx_rst_tb,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    input  logic                 aligned,
    input  logic                 ber_count_clr,
    output logic                 rx_high_ber,
    output logic [5:0]           ber_count,
    output logic [5:0]           win_err_count
);

    localparam int                 TIMER_W    = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COUNT_125US - 1);
    localparam logic [5:0]         THRESH     = 6'(BER_THRESH);
    localparam logic [5:0]         BER_MAX    = 6'd63;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TEST   = 2'd1,
        ST_HI_BER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [5:0]         win_err_count_q, win_err_count_d;
    logic               rx_high_ber_q, rx_high_ber_d;
    logic [5:0]         ber_count_q, ber_count_d;

    // Only 01 and 10 are legal sync headers; equal bits mean a bad header.
    logic               hdr_bad;
    logic               expiry;
    logic [TIMER_W-1:0] timer_next;
    logic [5:0]         win_err_inc;
    logic               counted_bad;

    assign hdr_bad     = (serdes_rx_hdr[1] == serdes_rx_hdr[0]);
    assign expiry      = (timer_q == TIMER_LAST);
    assign timer_next  = expiry ? '0 : timer_q + TIMER_W'(1);
    assign win_err_inc = win_err_count_q + 6'd1;
    // Headers only count towards the cumulative total once the monitor is
    // past INIT; the header on the INIT->TEST edge is therefore ignored.
    assign counted_bad = hdr_bad && (state_q != ST_INIT);

    // Window FSM: next state, window timer, per-window errors and high-BER flag.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        win_err_count_d = win_err_count_q;
        rx_high_ber_d   = rx_high_ber_q;

        if (!aligned) begin
            // Loss of lock overrides every other transition.
            state_d         = ST_INIT;
            timer_d         = '0;
            win_err_count_d = '0;
            rx_high_ber_d   = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d         = ST_TEST;
                    timer_d         = '0;
                    win_err_count_d = '0;
                    rx_high_ber_d   = 1'b0;
                end
                ST_TEST: begin
                    timer_d = timer_next;
                    if (hdr_bad && (win_err_inc == THRESH)) begin
                        // Threshold wins over a coincident expiry.
                        state_d         = ST_HI_BER;
                        rx_high_ber_d   = 1'b1;
                        timer_d         = '0;
                        win_err_count_d = '0;
                    end else if (expiry) begin
                        // Window closed below threshold; the expiry-edge
                        // header does not carry into the new window.
                        rx_high_ber_d   = 1'b0;
                        win_err_count_d = '0;
                    end else if (hdr_bad) begin
                        win_err_count_d = win_err_inc;
                    end
                end
                ST_HI_BER: begin
                    timer_d         = timer_next;
                    win_err_count_d = '0;
                    if (expiry) begin
                        // Flag stays up until a full TEST window ends clean.
                        state_d = ST_TEST;
                    end
                end
                default: begin
                    state_d         = ST_INIT;
                    timer_d         = '0;
                    win_err_count_d = '0;
                    rx_high_ber_d   = 1'b0;
                end
            endcase
        end
    end

    // Cumulative bad-header counter: saturating, cleared by the management pulse.
    always_comb begin
        ber_count_d = ber_count_q;
        if (ber_count_clr) begin
            ber_count_d = counted_bad ? 6'd1 : 6'd0;
        end else if (counted_bad && (ber_count_q != BER_MAX)) begin
            ber_count_d = ber_count_q + 6'd1;
        end
    end

    // State and counter registers with asynchronous active-high reset.
    always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
        if (rx_rst_tb) begin
            state_q         <= ST_INIT;
            timer_q         <= '0;
            win_err_count_q <= '0;
            rx_high_ber_q   <= 1'b0;
            ber_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            win_err_count_q <= win_err_count_d;
            rx_high_ber_q   <= rx_high_ber_d;
            ber_count_q     <= ber_count_d;
        end
    end

    assign rx_high_ber   = rx_high_ber_q;
    assign ber_count     = ber_count_q;
    assign win_err_count = win_err_count_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_ber_mon.sv
// Bench for eth_phy_10g_rx_ber_mon. The driver applies one header per cycle
// and advances a window-level reference model, pushing the expected outputs
// for the coming edge; a monitor pops and compares after every rising edge.
module tb_eth_phy_10g_rx_ber_mon;

    localparam int COUNT  = 100;
    localparam int THRESH = 16;

    // Clock and reset
    logic       clk_tb = 1'b0;
    logic       rx_rst_tb = 1'b1;
    logic [1:0] serdes_rx_hdr = 2'b11;
    logic       aligned = 1'b0;
    logic       ber_count_clr = 1'b0;
    logic       rx_high_ber;
    logic [5:0] ber_count;
    logic [5:0] win_err_count;

    always #5 clk_tb = ~clk_tb;

    eth_phy_10g_rx_ber_mon #(
        .HDR_WIDTH  (2),
        .COUNT_125US(COUNT),
        .BER_THRESH (THRESH)
    ) dut (
        .clk_tb       (clk_tb),
        .rx_rst_tb    (rx_rst_tb),
        .serdes_rx_hdr(serdes_rx_hdr),
        .aligned      (aligned),
        .ber_count_clr(ber_count_clr),
        .rx_high_ber  (rx_high_ber),
        .ber_count    (ber_count),
        .win_err_count(win_err_count)
    );

    // Scoreboard state
    logic [12:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_pushed = 0;
    int          n_popped = 0;

    // Reference model: window bookkeeping in plain integers
    bit m_locked = 0;   // lock has been seen and the window machinery is running
    bit m_hi     = 0;   // inside a high-BER window (errors not collected)
    bit m_high   = 0;   // reported rx_high_ber
    int m_pos    = 0;   // headers already sampled in the current window
    int m_errs   = 0;   // bad headers collected in the current window
    int m_cum    = 0;   // cumulative bad headers, saturating at 63

    function automatic void model_reset();
        m_locked = 0; m_hi = 0; m_high = 0; m_pos = 0; m_errs = 0; m_cum = 0;
    endfunction

    function automatic void model_step(logic [1:0] hdr, logic al, logic clr);
        bit bad;
        bit counted;
        bad     = (hdr == 2'b00) || (hdr == 2'b11);
        counted = bad && m_locked;
        if (clr) m_cum = counted ? 1 : 0;
        else if (counted) m_cum = (m_cum + 1 > 63) ? 63 : m_cum + 1;

        if (!al) begin
            m_locked = 0; m_hi = 0; m_high = 0; m_pos = 0; m_errs = 0;
        end else if (!m_locked) begin
            m_locked = 1; m_hi = 0; m_high = 0; m_pos = 0; m_errs = 0;
        end else begin
            m_pos = m_pos + 1;
            if (!m_hi && bad && (m_errs + 1 == THRESH)) begin
                m_hi = 1; m_high = 1; m_pos = 0; m_errs = 0;
            end else if (m_pos == COUNT) begin
                if (!m_hi) m_high = 0;
                m_hi = 0; m_pos = 0; m_errs = 0;
            end else if (!m_hi && bad) begin
                m_errs = m_errs + 1;
            end
        end
    endfunction

    function automatic logic [1:0] rand_hdr(bit bad);
        if (bad) return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    // Driver: apply inputs on the falling edge, push the expected post-edge outputs.
    task automatic drive(input logic [1:0] hdr, input logic al, input logic clr, input logic rst);
        @(negedge clk_tb);
        serdes_rx_hdr = hdr;
        aligned       = al;
        ber_count_clr = clr;
        rx_rst_tb     = rst;
        if (rst) model_reset();
        else model_step(hdr, al, clr);
        exp_q.push_back({m_high, 6'(m_cum), 6'(m_errs)});
        n_pushed++;
    endtask

    task automatic check_direct(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) drive((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b0);
    endtask

    // One full window of COUNT headers with n_err bad ones spread out; with
    // last_on_expiry the final bad header lands on the expiry cycle.
    task automatic run_window(input int n_err, input bit last_on_expiry);
        int off;
        bit bad;
        off = $urandom_range(0, 5);
        for (int i = 0; i < COUNT; i++) begin
            if (last_on_expiry) bad = (((i % 6) == off) && (i < (n_err - 1) * 6)) || (i == COUNT - 1);
            else bad = ((i % 6) == off) && (i < n_err * 6);
            drive(rand_hdr(bad), 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Run clean headers until the model sits at the start of a TEST window.
    task automatic sync_window();
        for (int k = 0; k < 400 && (m_pos != 0 || m_hi || !m_locked); k++) begin
            drive(rand_hdr(1'b0), 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Monitor: compare every edge against the oldest expectation.
    initial begin
        logic [12:0] exp_v;
        logic [12:0] got_v;
        forever begin
            @(posedge clk_tb);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                n_popped++;
                got_v = {rx_high_ber, ber_count, win_err_count};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got high=%0b ber=%0d win=%0d expected high=%0b ber=%0d win=%0d",
                             $time, got_v[12], got_v[11:6], got_v[5:0], exp_v[12], exp_v[11:6], exp_v[5:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int p;
        // 1. reset and idle
        for (int i = 0; i < 50; i++) drive(2'b11, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(2'b11, 1'b0, 1'b0, 1'b0);

        // 2. clean link
        clean(1000);

        // 3. threshold edge: 15 bad, then 16 bad
        sync_window();
        run_window(THRESH - 1, 1'b0);
        run_window(THRESH, 1'b0);
        @(posedge clk_tb); #2;
        check_direct("scen3_high", int'(rx_high_ber), 1);
        check_direct("scen3_ber_count", int'(ber_count), 31);

        // 4. recovery
        clean(250);
        @(posedge clk_tb); #2;
        check_direct("scen4_recovered", int'(rx_high_ber), 0);

        // 5. threshold on expiry edge, then loss of lock
        sync_window();
        run_window(THRESH, 1'b1);
        @(posedge clk_tb); #2;
        check_direct("scen5_high", int'(rx_high_ber), 1);
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        @(posedge clk_tb); #2;
        check_direct("scen5_lock_high", int'(rx_high_ber), 0);
        check_direct("scen5_lock_win", int'(win_err_count), 0);
        check_direct("scen5_lock_ber", int'(ber_count), 47);
        clean(20);

        // 6. saturation and clear
        for (int i = 0; i < 100; i++) drive(2'b00, 1'b1, 1'b0, 1'b0);
        @(posedge clk_tb); #2;
        check_direct("scen6_sat", int'(ber_count), 63);
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        @(posedge clk_tb); #2;
        check_direct("scen6_clr_bad", int'(ber_count), 1);
        drive(2'b10, 1'b1, 1'b1, 1'b0);
        @(posedge clk_tb); #2;
        check_direct("scen6_clr_good", int'(ber_count), 0);

        // Randomised phase with varying error density, lock drops, clears and
        // one asynchronous reset mid-run.
        p = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = $urandom_range(0, 3) * 10;
            if (i == 1500) begin
                drive(2'b00, 1'b1, 1'b0, 1'b1);
                #1;
                check_direct("async_rst_high", int'(rx_high_ber), 0);
                check_direct("async_rst_ber", int'(ber_count), 0);
                check_direct("async_rst_win", int'(win_err_count), 0);
                for (int k = 0; k < 3; k++) drive(2'b11, 1'b1, 1'b0, 1'b1);
            end
            drive(rand_hdr($urandom_range(0, 99) < p),
                  ($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 99) == 0),
                  1'b0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_tb);
        #3;
        check_direct("queue_drained", exp_q.size(), 0);
        check_direct("pushed_vs_popped", n_popped, n_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
